tanh_rr_scheduler: RTL

//   Shares one tanh_calc instance (S1.5.6 sign-magnitude, combinational) among
//   N_REQ LSTM requesters, e.g. candidate-gate tanh and cell-state tanh(c_t).

---
 rtl/tanh_rr_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tanh_rr_scheduler.sv
// Round-robin sharing of one combinational tanh_calc among N_REQ requesters,
// with an operand register (S1) and an output register (S2) around the LUT.

// Piecewise-linear tanh on sign-magnitude operands; the sign passes through.
module tanh_calc #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned FRAC_BITS = 6
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  localparam int unsigned MW  = WIDTH - 1;
  localparam int unsigned ONE = 1 << FRAC_BITS;

  logic [MW-1:0] m;
  logic [MW-1:0] ym;

  assign m = x[MW-1:0];

  // Breakpoints at 0.5, 1, 2, 3; slopes 1, 1/2, 3/16, 1/16; saturates to 1.0.
  always_comb begin
    ym = MW'(ONE);
    if (m < MW'(ONE / 2))          ym = m;
    else if (m < MW'(ONE))         ym = (m >> 1) + MW'(ONE / 4);
    else if (m < MW'(2 * ONE))     ym = (((m << 1) + m) >> 4) + MW'(9 * ONE / 16);
    else if (m < MW'(3 * ONE))     ym = (m >> 4) + MW'(13 * ONE / 16);
  end

  assign y = {x[WIDTH-1], ym};
endmodule

module tanh_rr_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned FRAC_BITS = 6,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       ops_done,
  output logic                   busy
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [ID_W-1:0]  s1_id;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             accept;
  logic             s1_free;
  logic             s2_free;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] tanh_y;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;
  assign accept  = found && s1_free && !rst;
  assign busy    = s1_valid || rsp_valid;

  // First valid requester searching upward from ptr, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] && ((32'(ptr) + k) % N_REQ) == i) begin
          found = 1'b1;
          win   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(win) == i) begin
        sel_data     = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = accept;
      end
    end
  end

  tanh_calc #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_tanh (
    .x (s1_data),
    .y (tanh_y)
  );

  // S1 refills in the same cycle it drains into S2, giving full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ops_done  <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        s1_data <= sel_data;
        s1_id   <= win;
        ptr     <= (32'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
      end
      if (s1_valid && s2_free) begin
        rsp_data <= tanh_y;
        rsp_id   <= s1_id;
      end
      s1_valid  <= accept || (s1_valid && !s2_free);
      rsp_valid <= (s1_valid && s2_free) || (rsp_valid && !rsp_ready);
      if (rsp_valid && rsp_ready) ops_done <= ops_done + CNT_W'(1);
    end
  end
endmodule
